pipe_execute: RTL and testbench
===============================

// Module: pipe_execute
// PURPOSE
//  Y86-64 pipelined E stage. Consumes the E_* fields latched by the D->E register.
//  Computes the ALU result valE, holds the ZF/SF/OF condition-code register, and
//  evaluates jXX/cmovXX conditions. Drives e_* signals to the E->M register and the
//  decode forwarding logic. The only state is CC (plus optional stats counters).
// PARAMETERS
//  W     64  datapath width (fixed 64 for Y86-64)
//  RNONE 4'hF  "no register" ID
// PORTS
//  clk      in   1   rising-edge clock
//  rst_n    in   1   synchronous reset, active low
//  E_stat   in   2   0=AOK 1=HLT 2=ADR 3=INS
//  E_icode  in   4   instruction code
//  E_ifun   in   4   function code
//  E_valC   in   64  constant word
//  E_valA   in   64  operand A
//  E_valB   in   64  operand B
//  E_dstE   in   4   ALU destination register ID
//  E_dstM   in   4   memory destination register ID
//  m_stat   in   2   stat of the instruction now in M
//  W_stat   in   2   stat of the instruction now in W
//  e_stat   out  2   =E_stat
//  e_icode  out  4   =E_icode
//  e_valE   out  64  ALU result
//  e_valA   out  64  =E_valA
//  e_dstE   out  4   E_dstE, or RNONE for an untaken cmov
//  e_dstM   out  4   =E_dstM
//  e_Cnd    out  1   condition result for jXX/cmovXX
//  cc       out  3   {ZF,SF,OF} register
// BEHAVIOUR
//  - Reset: clk and synchronous active-low rst_n. While rst_n=0:
//    - cc <= 3'b100 at the clock edge;
//    - combinational outputs are gated: e_valE=0, e_dstE=e_dstM=RNONE, e_Cnd=0, e_stat=0, e_icode=1 (nop), e_valA=0.
//    Reset takes precedence over a CC update in the same cycle.
//  - aluA select:
//    - E_valA for icode 2 (rrmov/cmov) or 6 (OPq);
//    - E_valC for icode 3, 4, 5;
//    - -8 for icode 8 or A;
//    - +8 for icode 9 or B;
//    - otherwise 0.
//  - aluB select: E_valB for icode 4, 5, 6, 8, 9, A, B; otherwise 0.
//  - alufun: E_ifun when icode=6, otherwise ADD(0).
//    - 0 ADD: B+A;
//    - 1 SUB: B-A;
//    - 2 AND: B&A;
//    - 3 XOR: B^A;
//    - ifun>3 on OPq: result 0, CC unchanged (decode already flagged INS).
//    Arithmetic is mod 2^64, two's complement, no carry kept.
//  - Flags:
//    - ZF = (t==0); SF = t[63].
//    - OF on ADD: (a[63]==b[63]) && (t[63]!=a[63]).
//    - OF on SUB: (a[63]!=b[63]) && (t[63]!=b[63]).
//    - OF=0 on AND/XOR.
//  - set_cc = E_icode==6 && ifun<=3 && E_stat==AOK && m_stat==AOK && W_stat==AOK && rst_n.
//    When set_cc is true, cc <= flags at the next posedge; otherwise cc holds.
//    This suppresses CC update behind an excepting instruction.
//  - e_Cnd is combinational from the current registered cc (value before this cycle's update):
//    - 0 always: 1;
//    - 1 le: (SF^OF)|ZF;
//    - 2 l: SF^OF;
//    - 3 e: ZF;
//    - 4 ne: !ZF;
//    - 5 ge: !(SF^OF);
//    - 6 g: !(SF^OF)&!ZF;
//    - ifun>6: 0.
//  - e_dstE = RNONE when icode=2 && !e_Cnd; otherwise E_dstE.
//  - Latency: e_* outputs are combinational (0 cycles). CC is visible to the next instruction 1 cycle later.
//  - Back-to-back OPq then jXX/cmov: the following instruction sees the updated cc. No bubble required.
// CONFIGURATION
//  EXEC_STATS_EN defined: adds outputs stat_ccupd[31:0] and stat_taken[31:0].
//    - Both reset to 0.
//    - stat_ccupd increments on each set_cc cycle.
//    - stat_taken increments when E_stat==AOK && (icode==7 || icode==2) && e_Cnd.
//    - Both wrap 2^32-1 -> 0.
//  EXEC_STATS_EN undefined: the ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset, then observe cc -> 3'b100. With rst_n=0 and any E_*: e_dstE=F, e_valE=0.
//  2. OPq ADD, valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> e_valE=0x8000_0000_0000_0000; next cycle cc={0,1,1}.
//  3. OPq SUB, valA=5, valB=5 -> e_valE=0, cc={1,0,0}. Then jXX ifun=3 (je) -> e_Cnd=1.
//     Then cmovne (icode 2, ifun 4) with dstE=3 -> e_dstE=F.
//  4. OPq AND with m_stat=ADR (or W_stat=HLT) -> cc unchanged; e_valE still the AND result.
//  5. call (icode 8) valB=0x100 -> e_valE=0xF8. ret (icode 9) valB=0xF8 -> e_valE=0x100.
//     mrmovq valC=0x10, valB=0x20 -> e_valE=0x30.
//  6. EXEC_STATS_EN defined: 3 taken jXX plus 2 OPq -> stat_taken=3, stat_ccupd=2.
//     Preload 0xFFFF_FFFF, apply 1 more taken -> stat_taken=0.

Source files
------------

// File: rtl/pipe_execute.sv
// Y86-64 pipelined execute (E) stage.
// Computes the ALU result, holds the {ZF,SF,OF} condition codes and evaluates
// jXX/cmovXX conditions. The e_* outputs are combinational.
// Optional feature macro: EXEC_STATS_EN adds the stat_ccupd/stat_taken counters.
module pipe_execute #(
    parameter int         W     = 64,
    parameter logic [3:0] RNONE = 4'hF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valC,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [1:0]   m_stat,
    input  logic [1:0]   W_stat,
    output logic [1:0]   e_stat,
    output logic [3:0]   e_icode,
    output logic [W-1:0] e_valE,
    output logic [W-1:0] e_valA,
    output logic [3:0]   e_dstE,
    output logic [3:0]   e_dstM,
    output logic         e_Cnd,
`ifdef EXEC_STATS_EN
    output logic [31:0]  stat_ccupd,
    output logic [31:0]  stat_taken,
`endif
    output logic [2:0]   cc
);

    localparam logic [1:0] STAT_AOK = 2'd0;

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] A_ADD = 4'h0;
    localparam logic [3:0] A_SUB = 4'h1;
    localparam logic [3:0] A_AND = 4'h2;
    localparam logic [3:0] A_XOR = 4'h3;

    logic [2:0]   cc_q, cc_d;
    logic [W-1:0] alu_a, alu_b, alu_t;
    logic [3:0]   alu_fun;
    logic         zf_new, sf_new, of_new;
    logic         set_cc;
    logic         cnd_raw;
    logic         zf, sf, of;

    assign cc = cc_q;
    assign zf = cc_q[2];
    assign sf = cc_q[1];
    assign of = cc_q[0];

    // ALU operand selection, function and flag generation
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_fun = (E_icode == I_OPQ) ? E_ifun : A_ADD;
        unique case (E_icode)
            I_RRMOVQ, I_OPQ:           alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ,
            I_MRMOVQ:                  alu_a = E_valC;
            I_CALL, I_PUSHQ:           alu_a = -W'(64'd8);
            I_RET, I_POPQ:             alu_a = W'(64'd8);
            default:                   alu_a = '0;
        endcase
        unique case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ, I_CALL,
            I_RET, I_PUSHQ, I_POPQ:    alu_b = E_valB;
            default:                   alu_b = '0;
        endcase

        of_new = 1'b0;
        unique case (alu_fun)
            A_ADD: begin
                alu_t  = alu_b + alu_a;
                of_new = (alu_a[W-1] == alu_b[W-1]) && (alu_t[W-1] != alu_a[W-1]);
            end
            A_SUB: begin
                alu_t  = alu_b - alu_a;
                of_new = (alu_a[W-1] != alu_b[W-1]) && (alu_t[W-1] != alu_b[W-1]);
            end
            A_AND:   alu_t = alu_b & alu_a;
            A_XOR:   alu_t = alu_b ^ alu_a;
            default: alu_t = '0;
        endcase
        zf_new = (alu_t == '0);
        sf_new = alu_t[W-1];
    end

    // CC write enable: only a valid OPq with no exception in E, M or W
    always_comb begin
        set_cc = (E_icode == I_OPQ) && (E_ifun <= A_XOR) && (E_stat == STAT_AOK)
                 && (m_stat == STAT_AOK) && (W_stat == STAT_AOK) && rst_n;
    end

    // Branch/cmov condition from the registered CC
    always_comb begin
        unique case (E_ifun)
            4'd0:    cnd_raw = 1'b1;
            4'd1:    cnd_raw = (sf ^ of) | zf;
            4'd2:    cnd_raw = sf ^ of;
            4'd3:    cnd_raw = zf;
            4'd4:    cnd_raw = !zf;
            4'd5:    cnd_raw = !(sf ^ of);
            4'd6:    cnd_raw = !(sf ^ of) && !zf;
            default: cnd_raw = 1'b0;
        endcase
    end

    // Output drive, forced to a nop-like bubble while reset is asserted
    always_comb begin
        if (!rst_n) begin
            e_stat  = '0;
            e_icode = I_NOP;
            e_valE  = '0;
            e_valA  = '0;
            e_dstE  = RNONE;
            e_dstM  = RNONE;
            e_Cnd   = 1'b0;
        end else begin
            e_stat  = E_stat;
            e_icode = E_icode;
            e_valE  = alu_t;
            e_valA  = E_valA;
            e_dstM  = E_dstM;
            e_Cnd   = cnd_raw;
            e_dstE  = ((E_icode == I_RRMOVQ) && !cnd_raw) ? RNONE : E_dstE;
        end
    end

    // Next CC value; reset overrides an update in the same cycle
    always_comb begin
        if (!rst_n)      cc_d = 3'b100;
        else if (set_cc) cc_d = {zf_new, sf_new, of_new};
        else             cc_d = cc_q;
    end

    // Condition-code register
    always_ff @(posedge clk) begin
        cc_q <= cc_d;
    end

`ifdef EXEC_STATS_EN
    logic [31:0] stat_ccupd_q, stat_ccupd_d;
    logic [31:0] stat_taken_q, stat_taken_d;
    logic        taken;

    assign stat_ccupd = stat_ccupd_q;
    assign stat_taken = stat_taken_q;

    // Statistics counter next-state; both wrap naturally at 2^32
    always_comb begin
        taken = (E_stat == STAT_AOK) && ((E_icode == I_JXX) || (E_icode == I_RRMOVQ)) && e_Cnd;
        if (!rst_n) begin
            stat_ccupd_d = '0;
            stat_taken_d = '0;
        end else begin
            stat_ccupd_d = set_cc ? stat_ccupd_q + 32'd1 : stat_ccupd_q;
            stat_taken_d = taken  ? stat_taken_q + 32'd1 : stat_taken_q;
        end
    end

    // Statistics counter registers
    always_ff @(posedge clk) begin
        stat_ccupd_q <= stat_ccupd_d;
        stat_taken_q <= stat_taken_d;
    end
`endif

endmodule

// File: tb/tb_pipe_execute.sv
// Directed self-checking bench for pipe_execute.
// Stats checks are compiled in only when EXEC_STATS_EN is defined.
module tb_pipe_execute;

    logic        clk;
    logic        rst_n;
    logic [1:0]  E_stat;
    logic [3:0]  E_icode;
    logic [3:0]  E_ifun;
    logic [63:0] E_valC;
    logic [63:0] E_valA;
    logic [63:0] E_valB;
    logic [3:0]  E_dstE;
    logic [3:0]  E_dstM;
    logic [1:0]  m_stat;
    logic [1:0]  W_stat;
    logic [1:0]  e_stat;
    logic [3:0]  e_icode;
    logic [63:0] e_valE;
    logic [63:0] e_valA;
    logic [3:0]  e_dstE;
    logic [3:0]  e_dstM;
    logic        e_Cnd;
    logic [2:0]  cc;
`ifdef EXEC_STATS_EN
    logic [31:0] stat_ccupd;
    logic [31:0] stat_taken;
`endif

    int checks = 0;
    int errors = 0;

    pipe_execute #(.W(64), .RNONE(4'hF)) dut (
        .clk(clk), .rst_n(rst_n),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat),
        .e_stat(e_stat), .e_icode(e_icode), .e_valE(e_valE), .e_valA(e_valA),
        .e_dstE(e_dstE), .e_dstM(e_dstM), .e_Cnd(e_Cnd),
`ifdef EXEC_STATS_EN
        .stat_ccupd(stat_ccupd), .stat_taken(stat_taken),
`endif
        .cc(cc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply one instruction to the E inputs (statuses default to AOK)
    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] valc, input logic [63:0] vala,
                         input logic [63:0] valb, input logic [3:0] dste);
        E_stat  = 2'd0;
        m_stat  = 2'd0;
        W_stat  = 2'd0;
        E_icode = icode;
        E_ifun  = ifun;
        E_valC  = valc;
        E_valA  = vala;
        E_valB  = valb;
        E_dstE  = dste;
        E_dstM  = 4'h7;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'h2);
        E_stat = 2'd1;
        #1;
        checks++; if (e_valE !== 64'h0) begin errors++; $display("FAIL rst_valE got %h exp 0", e_valE); end
        checks++; if (e_dstE !== 4'hF) begin errors++; $display("FAIL rst_dstE got %h exp F", e_dstE); end
        checks++; if (e_dstM !== 4'hF) begin errors++; $display("FAIL rst_dstM got %h exp F", e_dstM); end
        checks++; if (e_icode !== 4'h1 || e_stat !== 2'd0 || e_valA !== 64'h0 || e_Cnd !== 1'b0) begin
            errors++; $display("FAIL rst_gated icode=%h stat=%h valA=%h cnd=%b exp 1/0/0/0", e_icode, e_stat, e_valA, e_Cnd);
        end
        next_cycle();
        next_cycle();
        checks++; if (cc !== 3'b100) begin errors++; $display("FAIL rst_cc got %b exp 100", cc); end
        rst_n = 1'b1;
    endtask

    task automatic test_add_overflow();
        drive(4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'h2);
        checks++; if (e_valE !== 64'h8000_0000_0000_0000) begin errors++; $display("FAIL add_valE got %h exp 8000000000000000", e_valE); end
        checks++; if (e_dstE !== 4'h2 || e_icode !== 4'h6 || e_valA !== 64'h7FFF_FFFF_FFFF_FFFF || e_dstM !== 4'h7) begin
            errors++; $display("FAIL add_pass dstE=%h icode=%h dstM=%h exp 2/6/7", e_dstE, e_icode, e_dstM);
        end
        checks++; if (cc !== 3'b100) begin errors++; $display("FAIL add_cc_before got %b exp 100", cc); end
        next_cycle();
        checks++; if (cc !== 3'b011) begin errors++; $display("FAIL add_cc got %b exp 011", cc); end
    endtask

    task automatic test_sub_cond();
        drive(4'h6, 4'h1, 64'h0, 64'h5, 64'h5, 4'h2);
        checks++; if (e_valE !== 64'h0) begin errors++; $display("FAIL sub_valE got %h exp 0", e_valE); end
        next_cycle();
        checks++; if (cc !== 3'b100) begin errors++; $display("FAIL sub_cc got %b exp 100", cc); end
        drive(4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 4'hF);
        checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL je_taken got %b exp 1", e_Cnd); end
        drive(4'h7, 4'h4, 64'h0, 64'h0, 64'h0, 4'hF);
        checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL jne got %b exp 0", e_Cnd); end
        drive(4'h2, 4'h4, 64'h0, 64'h55, 64'h99, 4'h3);
        checks++; if (e_dstE !== 4'hF || e_valE !== 64'h55) begin
            errors++; $display("FAIL cmovne dstE=%h valE=%h exp F/55", e_dstE, e_valE);
        end
        drive(4'h2, 4'h0, 64'h0, 64'h55, 64'h99, 4'h3);
        checks++; if (e_dstE !== 4'h3) begin errors++; $display("FAIL rrmovq_dstE got %h exp 3", e_dstE); end
        // SUB signed overflow: 0x8000.. - 1 -> 0x7FFF.., OF=1
        drive(4'h6, 4'h1, 64'h0, 64'h1, 64'h8000_0000_0000_0000, 4'h2);
        checks++; if (e_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL subov_valE got %h", e_valE); end
        next_cycle();
        checks++; if (cc !== 3'b001) begin errors++; $display("FAIL subov_cc got %b exp 001", cc); end
        drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF);
        checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL jl got %b exp 1", e_Cnd); end
        drive(4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 4'hF);
        checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL jle got %b exp 1", e_Cnd); end
        drive(4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 4'hF);
        checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL jge got %b exp 0", e_Cnd); end
        drive(4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 4'hF);
        checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL jg got %b exp 0", e_Cnd); end
        drive(4'h7, 4'h7, 64'h0, 64'h0, 64'h0, 4'hF);
        checks++; if (e_Cnd !== 1'b0) begin errors++; $display("FAIL ifun7 got %b exp 0", e_Cnd); end
        drive(4'h7, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
        checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL jmp got %b exp 1", e_Cnd); end
        // XOR: 0xFF ^ 0xF0 = 0x0F, flags 000
        drive(4'h6, 4'h3, 64'h0, 64'hF0, 64'hFF, 4'h2);
        checks++; if (e_valE !== 64'h0F) begin errors++; $display("FAIL xor_valE got %h exp f", e_valE); end
        next_cycle();
        checks++; if (cc !== 3'b000) begin errors++; $display("FAIL xor_cc got %b exp 000", cc); end
    endtask

    task automatic test_exception_suppress();
        drive(4'h6, 4'h2, 64'h0, 64'h0, 64'hFF, 4'h2);
        m_stat = 2'd2;
        #1;
        checks++; if (e_valE !== 64'h0) begin errors++; $display("FAIL and_adr_valE got %h exp 0", e_valE); end
        next_cycle();
        checks++; if (cc !== 3'b000) begin errors++; $display("FAIL and_adr_cc got %b exp 000", cc); end
        m_stat = 2'd0; W_stat = 2'd1;
        next_cycle();
        checks++; if (cc !== 3'b000) begin errors++; $display("FAIL and_hlt_cc got %b exp 000", cc); end
        W_stat = 2'd0; E_stat = 2'd3;
        next_cycle();
        checks++; if (cc !== 3'b000) begin errors++; $display("FAIL and_ins_cc got %b exp 000", cc); end
        // Invalid OPq function: result 0 and CC untouched
        drive(4'h6, 4'h5, 64'h0, 64'h3, 64'h3, 4'h2);
        checks++; if (e_valE !== 64'h0) begin errors++; $display("FAIL badfun_valE got %h exp 0", e_valE); end
        next_cycle();
        checks++; if (cc !== 3'b000) begin errors++; $display("FAIL badfun_cc got %b exp 000", cc); end
    endtask

    task automatic test_address();
        drive(4'h8, 4'h0, 64'h0, 64'h0, 64'h100, 4'h4);
        checks++; if (e_valE !== 64'hF8) begin errors++; $display("FAIL call got %h exp f8", e_valE); end
        drive(4'h9, 4'h0, 64'h0, 64'h0, 64'hF8, 4'h4);
        checks++; if (e_valE !== 64'h100) begin errors++; $display("FAIL ret got %h exp 100", e_valE); end
        drive(4'h5, 4'h0, 64'h10, 64'h0, 64'h20, 4'hF);
        checks++; if (e_valE !== 64'h30) begin errors++; $display("FAIL mrmovq got %h exp 30", e_valE); end
        drive(4'h4, 4'h0, 64'h8, 64'h0, 64'h10, 4'hF);
        checks++; if (e_valE !== 64'h18) begin errors++; $display("FAIL rmmovq got %h exp 18", e_valE); end
        drive(4'h3, 4'h0, 64'h1234, 64'h0, 64'h99, 4'h1);
        checks++; if (e_valE !== 64'h1234) begin errors++; $display("FAIL irmovq got %h exp 1234", e_valE); end
        drive(4'hA, 4'h0, 64'h0, 64'h0, 64'h50, 4'h4);
        checks++; if (e_valE !== 64'h48) begin errors++; $display("FAIL pushq got %h exp 48", e_valE); end
        drive(4'hB, 4'h0, 64'h0, 64'h0, 64'h48, 4'h4);
        checks++; if (e_valE !== 64'h50) begin errors++; $display("FAIL popq got %h exp 50", e_valE); end
        drive(4'h0, 4'h0, 64'h77, 64'h66, 64'h55, 4'hF);
        checks++; if (e_valE !== 64'h0) begin errors++; $display("FAIL halt got %h exp 0", e_valE); end
        next_cycle();
        checks++; if (cc !== 3'b000) begin errors++; $display("FAIL addr_cc got %b exp 000", cc); end
    endtask

    task automatic test_reset_precedence();
        drive(4'h6, 4'h0, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 4'h2);
        rst_n = 1'b0;
        next_cycle();
        checks++; if (cc !== 3'b100) begin errors++; $display("FAIL rst_prec_cc got %b exp 100", cc); end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        drive(4'h6, 4'h1, 64'h0, 64'h3, 64'h5, 4'h2);
        checks++; if (e_valE !== 64'h2) begin errors++; $display("FAIL b2b_sub got %h exp 2", e_valE); end
        next_cycle();
        drive(4'h2, 4'h6, 64'h0, 64'hAA, 64'h0, 4'h4);
        checks++; if (e_Cnd !== 1'b1 || e_dstE !== 4'h4) begin
            errors++; $display("FAIL b2b_cmovg cnd=%b dstE=%h exp 1/4", e_Cnd, e_dstE);
        end
        next_cycle();
        drive(4'h6, 4'h1, 64'h0, 64'h5, 64'h3, 4'h2);
        next_cycle();
        drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF);
        checks++; if (e_Cnd !== 1'b1) begin errors++; $display("FAIL b2b_jl got %b exp 1", e_Cnd); end
    endtask

`ifdef EXEC_STATS_EN
    task automatic test_stats();
        rst_n = 1'b0;
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
        next_cycle();
        checks++; if (stat_ccupd !== 32'd0 || stat_taken !== 32'd0) begin
            errors++; $display("FAIL stats_rst ccupd=%0d taken=%0d exp 0/0", stat_ccupd, stat_taken);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(4'h7, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
            next_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            drive(4'h6, 4'h0, 64'h0, 64'h1, 64'h1, 4'h2);
            next_cycle();
        end
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
        next_cycle();
        checks++; if (stat_taken !== 32'd3) begin errors++; $display("FAIL stats_taken got %0d exp 3", stat_taken); end
        checks++; if (stat_ccupd !== 32'd2) begin errors++; $display("FAIL stats_ccupd got %0d exp 2", stat_ccupd); end
        force dut.stat_taken_q = 32'hFFFF_FFFF;
        #1;
        release dut.stat_taken_q;
        drive(4'h7, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
        next_cycle();
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
        checks++; if (stat_taken !== 32'd0) begin errors++; $display("FAIL stats_wrap got %0d exp 0", stat_taken); end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 4'hF);
        next_cycle();
        test_reset();
        test_add_overflow();
        test_sub_cond();
        test_exception_suppress();
        test_address();
        test_reset_precedence();
        test_back_to_back();
`ifdef EXEC_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
